// File: rtl/flash_read_sched.sv
`default_nettype none
// ============================================================================
// Module      : flash_read_sched
// Description : Two-port arbitrating SPI flash word reader. Each accepted
//               request issues a READ (0x03) with a 24-bit address and
//               returns one 32-bit little-endian word to the requester.
// Revision    : 1.0 - initial release
// ============================================================================
module flash_read_sched #(
    parameter int CLK_DIV  = 2,
    parameter int CSB_HIGH = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req0_valid,
    input  logic [23:0] req0_addr,
    output logic        req0_ready,
    output logic        req0_rvalid,
    output logic [31:0] req0_rdata,
    input  logic        req1_valid,
    input  logic [23:0] req1_addr,
    output logic        req1_ready,
    output logic        req1_rvalid,
    output logic [31:0] req1_rdata,
    output logic        flash_csb,
    output logic        flash_clk,
    output logic        flash_io0,
    input  logic        flash_io1
);

    localparam logic [3:0] c_DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [3:0] c_GAP_LAST = 4'(CSB_HIGH - 1);
    localparam logic [5:0] c_BIT_LAST = 6'd63;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_last_grant;
    logic        r_port;
    logic [63:0] r_shift;
    logic [31:0] r_rx;
    logic [3:0]  r_div_cnt;
    logic [3:0]  r_gap_cnt;
    logic [5:0]  r_bit_cnt;
    logic        r_sck;
    logic        r_csb;
    logic        r_rvalid0;
    logic        r_rvalid1;
    logic [31:0] r_rdata0;
    logic [31:0] r_rdata1;

    logic        w_gnt0;
    logic        w_gnt1;
    logic [23:0] w_addr;
    logic        w_accept;
    logic        w_tick;
    logic        w_done;
    logic        w_gap_end;
    logic [31:0] w_rx_word;

    // Round-robin grant: a lone requester always wins, a tie goes to the port not served last.
    always_comb begin
        w_gnt0 = req0_valid && (!req1_valid || r_last_grant);
        w_gnt1 = req1_valid && (!req0_valid || !r_last_grant);
        w_addr = w_gnt1 ? req1_addr : req0_addr;
    end

    assign w_accept  = (r_state == S_IDLE) && (w_gnt0 || w_gnt1);
    assign w_tick    = (r_state == S_XFER) && (r_div_cnt == c_DIV_LAST);
    assign w_done    = w_tick && r_sck && (r_bit_cnt == c_BIT_LAST);
    assign w_gap_end = (r_state == S_GAP) && (r_gap_cnt == c_GAP_LAST);

    // The first received byte arrives in the top of r_rx and belongs in the low byte of the word.
    assign w_rx_word = {r_rx[7:0], r_rx[15:8], r_rx[23:16], r_rx[31:24]};

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; ready is only offered while idle.
    always_comb begin
        w_state_nxt = r_state;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        case (r_state)
            S_IDLE: begin
                req0_ready = w_gnt0;
                req1_ready = w_gnt1;
                if (w_gnt0 || w_gnt1) begin
                    w_state_nxt = S_XFER;
                end
            end
            S_XFER: begin
                if (w_done) begin
                    w_state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (w_gap_end) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Serial engine: SCK divider, command/address shifter, MISO capture and csb gap timer.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_csb        <= 1'b1;
            r_sck        <= 1'b0;
            r_shift      <= '0;
            r_rx         <= '0;
            r_div_cnt    <= '0;
            r_bit_cnt    <= '0;
            r_gap_cnt    <= '0;
            r_port       <= 1'b0;
            r_last_grant <= 1'b1;
        end else if (w_accept) begin
            r_port       <= w_gnt1;
            r_last_grant <= w_gnt1;
            r_shift      <= {8'h03, w_addr, 32'h0000_0000};
            r_csb        <= 1'b0;
            r_sck        <= 1'b0;
            r_div_cnt    <= '0;
            r_bit_cnt    <= '0;
        end else if (r_state == S_XFER) begin
            if (!w_tick) begin
                r_div_cnt <= r_div_cnt + 4'd1;
            end else begin
                r_div_cnt <= '0;
                if (!r_sck) begin
                    // Rising edge: capture MISO; only the last 32 samples survive.
                    r_sck <= 1'b1;
                    r_rx  <= {r_rx[30:0], flash_io1};
                end else if (r_bit_cnt == c_BIT_LAST) begin
                    r_sck     <= 1'b0;
                    r_csb     <= 1'b1;
                    r_shift   <= '0;
                    r_gap_cnt <= '0;
                end else begin
                    // Falling edge: present the next MOSI bit.
                    r_sck     <= 1'b0;
                    r_bit_cnt <= r_bit_cnt + 6'd1;
                    r_shift   <= {r_shift[62:0], 1'b0};
                end
            end
        end else if (r_state == S_GAP) begin
            r_gap_cnt <= r_gap_cnt + 4'd1;
        end
    end

    // Response: one-cycle rvalid to the owning port, rdata held until that port's next completion.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
        end else begin
            r_rvalid0 <= w_done && !r_port;
            r_rvalid1 <= w_done && r_port;
            if (w_done && !r_port) begin
                r_rdata0 <= w_rx_word;
            end
            if (w_done && r_port) begin
                r_rdata1 <= w_rx_word;
            end
        end
    end

    assign flash_csb   = r_csb;
    assign flash_clk   = r_sck;
    assign flash_io0   = r_shift[63];
    assign req0_rvalid = r_rvalid0;
    assign req1_rvalid = r_rvalid1;
    assign req0_rdata  = r_rdata0;
    assign req1_rdata  = r_rdata1;

endmodule
`default_nettype wire

// File: tb/tb_flash_read_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_flash_read_sched
// Description : Self-checking bench for flash_read_sched with a behavioural
//               SPI flash model and an expected-response queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_flash_read_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [0:1023];

    typedef struct {
        logic        port;
        logic [23:0] addr;
        logic [31:0] data;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    // DUT with CLK_DIV=2
    logic        resetn;
    logic        req0_valid, req1_valid;
    logic [23:0] req0_addr, req1_addr;
    logic        req0_ready, req1_ready, req0_rvalid, req1_rvalid;
    logic [31:0] req0_rdata, req1_rdata;
    logic        flash_csb, flash_clk, flash_io0;
    logic        flash_io1 = 1'b0;

    // DUT with CLK_DIV=1
    logic        b_valid0, b_valid1;
    logic [23:0] b_addr0, b_addr1;
    logic        b_ready0, b_ready1, b_rvalid0, b_rvalid1;
    logic [31:0] b_rdata0, b_rdata1;
    logic        b_csb, b_sck, b_io0;
    logic        b_io1 = 1'b0;

    flash_read_sched #(.CLK_DIV(2), .CSB_HIGH(4)) u_dut (
        .clk(clk), .resetn(resetn),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
        .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready),
        .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata),
        .flash_csb(flash_csb), .flash_clk(flash_clk), .flash_io0(flash_io0), .flash_io1(flash_io1)
    );

    flash_read_sched #(.CLK_DIV(1), .CSB_HIGH(4)) u_dut_div1 (
        .clk(clk), .resetn(resetn),
        .req0_valid(b_valid0), .req0_addr(b_addr0), .req0_ready(b_ready0),
        .req0_rvalid(b_rvalid0), .req0_rdata(b_rdata0),
        .req1_valid(b_valid1), .req1_addr(b_addr1), .req1_ready(b_ready1),
        .req1_rvalid(b_rvalid1), .req1_rdata(b_rdata1),
        .flash_csb(b_csb), .flash_clk(b_sck), .flash_io0(b_io0), .flash_io1(b_io1)
    );

    function automatic logic [31:0] exp_word(input logic [23:0] a);
        int i;
        i = int'(a[9:0]);
        return {mem[(i + 3) % 1024], mem[(i + 2) % 1024], mem[(i + 1) % 1024], mem[i]};
    endfunction

    // Flash model A: shifts in cmd/addr on SCK rise, drives data on SCK fall.
    int          fa_cnt = 0;
    logic [31:0] fa_in = '0;
    logic [7:0]  fa_cmd = '0;
    logic [23:0] fa_addr = '0;
    logic [7:0]  fa_byte;
    always @(negedge flash_csb) fa_cnt = 0;
    always @(posedge flash_clk) begin
        if (flash_csb == 1'b0) begin
            fa_in  = {fa_in[30:0], flash_io0};
            fa_cnt = fa_cnt + 1;
            if (fa_cnt == 32) begin
                fa_cmd  = fa_in[31:24];
                fa_addr = fa_in[23:0];
            end
        end
    end
    always @(negedge flash_clk) begin
        if (flash_csb == 1'b0 && fa_cnt >= 32 && fa_cnt < 64) begin
            fa_byte   = mem[(int'(fa_addr[9:0]) + (fa_cnt - 32) / 8) % 1024];
            flash_io1 = fa_byte[7 - ((fa_cnt - 32) % 8)];
        end
    end

    // Flash model B for the CLK_DIV=1 instance.
    int          fb_cnt = 0;
    logic [31:0] fb_in = '0;
    logic [23:0] fb_addr = '0;
    logic [7:0]  fb_byte;
    always @(negedge b_csb) fb_cnt = 0;
    always @(posedge b_sck) begin
        if (b_csb == 1'b0) begin
            fb_in  = {fb_in[30:0], b_io0};
            fb_cnt = fb_cnt + 1;
            if (fb_cnt == 32) fb_addr = fb_in[23:0];
        end
    end
    always @(negedge b_sck) begin
        if (b_csb == 1'b0 && fb_cnt >= 32 && fb_cnt < 64) begin
            fb_byte = mem[(int'(fb_addr[9:0]) + (fb_cnt - 32) / 8) % 1024];
            b_io1   = fb_byte[7 - ((fb_cnt - 32) % 8)];
        end
    end

    task automatic do_reset();
        resetn     = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_addr  = '0;   req1_addr  = '0;
        b_valid0   = 1'b0; b_valid1   = 1'b0;
        b_addr0    = '0;   b_addr1    = '0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn     = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_addr  = '0;   req1_addr  = '0;
        b_valid0   = 1'b0; b_valid1   = 1'b0;
        b_addr0    = '0;   b_addr1    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (flash_csb !== 1'b1) begin errors++; $display("FAIL reset_csb: got %b expected 1", flash_csb); end
        checks++; if (flash_clk !== 1'b0) begin errors++; $display("FAIL reset_sck: got %b expected 0", flash_clk); end
        checks++; if (flash_io0 !== 1'b0) begin errors++; $display("FAIL reset_io0: got %b expected 0", flash_io0); end
        checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b expected 00", {req0_ready, req1_ready}); end
        checks++; if ({req0_rvalid, req1_rvalid} !== 2'b00) begin errors++; $display("FAIL reset_rvalid: got %b expected 00", {req0_rvalid, req1_rvalid}); end
        checks++; if (req0_rdata !== 32'h0 || req1_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h/%h expected 0/0", req0_rdata, req1_rdata); end
        @(posedge clk); #1 resetn = 1'b1;
        @(negedge clk);
        checks++; if (flash_csb !== 1'b1) begin errors++; $display("FAIL idle_csb: got %b expected 1", flash_csb); end
    endtask

    task automatic test_single_read();
        exp_t e;
        bit got = 0, seen1 = 0, rv_late = 0;
        int first_rise = -1;
        logic prev_sck = 1'b0;
        @(posedge clk); #1 req0_addr = 24'h000100; req0_valid = 1'b1;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (req0_ready) begin
                got = 1; e.port = 1'b0; e.addr = req0_addr; e.data = exp_word(req0_addr); e.cyc = cyc;
                sb.push_back(e);
            end
        end
        checks++; if (!got) begin errors++; $display("FAIL single_accept: got no ready expected ready within 20 cycles"); end
        @(posedge clk); #1 req0_valid = 1'b0;
        got = 0;
        for (int n = 0; n < 600 && !got; n++) begin
            @(negedge clk);
            if (flash_clk && !prev_sck && first_rise < 0) first_rise = cyc;
            prev_sck = flash_clk;
            if (req1_rvalid) seen1 = 1;
            if (req0_rvalid) got = 1;
        end
        checks++;
        if (!got || sb.size() == 0) begin
            errors++; $display("FAIL single_rvalid: got timeout expected req0_rvalid");
        end else begin
            e = sb.pop_front();
            if (first_rise - e.cyc != 3) begin errors++; $display("FAIL single_first_rise: got %0d expected 3", first_rise - e.cyc); end
            checks++; if (req0_rdata !== e.data) begin errors++; $display("FAIL single_data_model: got %h expected %h", req0_rdata, e.data); end
            checks++; if (req0_rdata !== 32'h0000_0013) begin errors++; $display("FAIL single_data: got %h expected 00000013", req0_rdata); end
            checks++; if (cyc - e.cyc != 257) begin errors++; $display("FAIL single_latency: got %0d expected 257", cyc - e.cyc); end
            checks++; if (fa_cmd !== 8'h03 || fa_addr !== 24'h000100) begin errors++; $display("FAIL single_mosi: got %h %h expected 03 000100", fa_cmd, fa_addr); end
        end
        @(negedge clk);
        if (req0_rvalid) rv_late = 1;
        checks++; if (rv_late) begin errors++; $display("FAIL single_pulse: got rvalid 2 cycles expected 1"); end
        checks++; if (req0_rdata !== 32'h0000_0013) begin errors++; $display("FAIL single_hold: got %h expected 00000013", req0_rdata); end
        checks++; if (seen1) begin errors++; $display("FAIL single_port1_quiet: got req1_rvalid expected none"); end
    endtask

    task automatic test_endian();
        exp_t e;
        bit got = 0;
        @(posedge clk); #1 req1_addr = 24'h000200; req1_valid = 1'b1;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (req1_ready) begin
                got = 1; e.port = 1'b1; e.addr = req1_addr; e.data = exp_word(req1_addr); e.cyc = cyc;
                sb.push_back(e);
            end
        end
        checks++; if (!got) begin errors++; $display("FAIL endian_accept: got no ready expected ready"); end
        @(posedge clk); #1 req1_valid = 1'b0;
        got = 0;
        for (int n = 0; n < 600 && !got; n++) begin
            @(negedge clk);
            if (req1_rvalid) got = 1;
        end
        checks++;
        if (!got || sb.size() == 0) begin
            errors++; $display("FAIL endian_rvalid: got timeout expected req1_rvalid");
        end else begin
            e = sb.pop_front();
            checks++; if (req1_rdata !== 32'h1234_5678) begin errors++; $display("FAIL endian_data: got %h expected 12345678", req1_rdata); end
            checks++; if (req1_rdata !== e.data) begin errors++; $display("FAIL endian_model: got %h expected %h", req1_rdata, e.data); end
        end
    endtask

    task automatic test_round_robin();
        exp_t e;
        int nacc = 0, nrv = 0, min_gap = 1000, gap_run = 0;
        bit had_low = 0, both_rdy = 0;
        logic acc_p[$];
        logic p;
        logic [31:0] d;
        do_reset();
        req0_addr = 24'h000300; req1_addr = 24'h000344;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int n = 0; n < 1500 && nrv < 3; n++) begin
            @(negedge clk);
            if (req0_ready && req1_ready) both_rdy = 1;
            if (req0_valid && req0_ready) begin
                e.port = 1'b0; e.addr = req0_addr; e.data = exp_word(req0_addr); e.cyc = cyc;
                sb.push_back(e); acc_p.push_back(1'b0); nacc++;
            end
            if (req1_valid && req1_ready) begin
                e.port = 1'b1; e.addr = req1_addr; e.data = exp_word(req1_addr); e.cyc = cyc;
                sb.push_back(e); acc_p.push_back(1'b1); nacc++;
            end
            if (flash_csb) begin
                gap_run++;
            end else begin
                if (had_low && gap_run > 0 && gap_run < min_gap) min_gap = gap_run;
                gap_run = 0; had_low = 1;
            end
            if (req0_rvalid || req1_rvalid) begin
                nrv++;
                p = req1_rvalid;
                d = req1_rvalid ? req1_rdata : req0_rdata;
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL rr_response: got unexpected rvalid on port %0d expected none", p);
                end else begin
                    e = sb.pop_front();
                    if (p !== e.port || d !== e.data || cyc - e.cyc != 257)
                        begin errors++; $display("FAIL rr_response: got port %0d data %h lat %0d expected port %0d data %h lat 257", p, d, cyc - e.cyc, e.port, e.data); end
                end
            end
            @(posedge clk); #1;
            if (nacc >= 3) begin req0_valid = 1'b0; req1_valid = 1'b0; end
        end
        checks++; if (nrv != 3) begin errors++; $display("FAIL rr_count: got %0d responses expected 3", nrv); end
        checks++;
        if (acc_p.size() != 3) begin
            errors++; $display("FAIL rr_order: got %0d grants expected 3", acc_p.size());
        end else if (acc_p[0] !== 1'b0 || acc_p[1] !== 1'b1 || acc_p[2] !== 1'b0) begin
            errors++; $display("FAIL rr_order: got %0d,%0d,%0d expected 0,1,0", acc_p[0], acc_p[1], acc_p[2]);
        end
        checks++; if (min_gap < 4 || min_gap >= 1000) begin errors++; $display("FAIL rr_csb_gap: got %0d expected >=4", min_gap); end
        checks++; if (both_rdy) begin errors++; $display("FAIL rr_ready_excl: got both ready expected one"); end
    endtask

    task automatic test_withdraw();
        exp_t e;
        bit got = 0, r1_rdy = 0, r1_rv = 0;
        int falls = 0, tail = -1;
        logic prev_csb;
        @(posedge clk); #1 req0_addr = 24'h000280; req0_valid = 1'b1;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (req0_ready) begin
                got = 1; e.port = 1'b0; e.addr = req0_addr; e.data = exp_word(req0_addr); e.cyc = cyc;
                sb.push_back(e);
            end
        end
        checks++; if (!got) begin errors++; $display("FAIL wd_accept: got no ready expected ready"); end
        @(posedge clk); #1 req0_valid = 1'b0;
        repeat (30) @(posedge clk);
        #1 req1_addr = 24'h000200; req1_valid = 1'b1;
        @(negedge clk);
        checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL wd_ready_busy: got %b expected 0", req1_ready); end
        @(posedge clk); #1 req1_valid = 1'b0;
        prev_csb = flash_csb; got = 0;
        for (int n = 0; n < 800 && tail != 0; n++) begin
            @(negedge clk);
            if (req1_ready) r1_rdy = 1;
            if (req1_rvalid) r1_rv = 1;
            if (prev_csb && !flash_csb) falls++;
            prev_csb = flash_csb;
            if (req0_rvalid && sb.size() != 0) begin
                got = 1; tail = 60;
                e = sb.pop_front();
                checks++;
                if (req0_rdata !== e.data || cyc - e.cyc != 257)
                    begin errors++; $display("FAIL wd_port0: got %h lat %0d expected %h lat 257", req0_rdata, cyc - e.cyc, e.data); end
            end else if (tail > 0) begin
                tail--;
            end
        end
        checks++; if (!got) begin errors++; $display("FAIL wd_rvalid: got timeout expected req0_rvalid"); end
        checks++; if (r1_rdy || r1_rv) begin errors++; $display("FAIL wd_port1: got ready %0d rvalid %0d expected 0 0", r1_rdy, r1_rv); end
        checks++; if (falls != 0) begin errors++; $display("FAIL wd_extra_xfer: got %0d new transactions expected 0", falls); end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        bit got = 0, any_rv = 0;
        int rises = 0;
        logic prev_sck = 1'b0;
        @(posedge clk); #1 req0_addr = 24'h000180; req0_valid = 1'b1;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (req0_ready) begin
                got = 1; e.port = 1'b0; e.addr = req0_addr; e.data = exp_word(req0_addr); e.cyc = cyc;
                sb.push_back(e);
            end
        end
        checks++; if (!got) begin errors++; $display("FAIL rm_accept: got no ready expected ready"); end
        @(posedge clk); #1 req0_valid = 1'b0;
        for (int n = 0; n < 600 && rises < 40; n++) begin
            @(negedge clk);
            if (flash_clk && !prev_sck) rises++;
            prev_sck = flash_clk;
        end
        checks++; if (rises != 40) begin errors++; $display("FAIL rm_rises: got %0d expected 40", rises); end
        resetn = 1'b0;
        sb.delete();
        @(negedge clk);
        checks++; if (flash_csb !== 1'b1 || flash_clk !== 1'b0) begin errors++; $display("FAIL rm_pins: got csb %b sck %b expected 1 0", flash_csb, flash_clk); end
        checks++; if (req0_rvalid !== 1'b0 || req0_rdata !== 32'h0) begin errors++; $display("FAIL rm_resp: got rvalid %b rdata %h expected 0 0", req0_rvalid, req0_rdata); end
        @(posedge clk); #1 resetn = 1'b1;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (req0_rvalid || req1_rvalid) any_rv = 1;
        end
        checks++; if (any_rv) begin errors++; $display("FAIL rm_no_rvalid: got rvalid expected none"); end
        got = 0;
        @(posedge clk); #1 req0_addr = 24'h000200; req0_valid = 1'b1;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (req0_ready) begin
                got = 1; e.port = 1'b0; e.addr = req0_addr; e.data = exp_word(req0_addr); e.cyc = cyc;
                sb.push_back(e);
            end
        end
        @(posedge clk); #1 req0_valid = 1'b0;
        got = 0;
        for (int n = 0; n < 600 && !got; n++) begin
            @(negedge clk);
            if (req0_rvalid) got = 1;
        end
        checks++;
        if (!got || sb.size() == 0) begin
            errors++; $display("FAIL rm_recover: got timeout expected req0_rvalid");
        end else begin
            e = sb.pop_front();
            if (req0_rdata !== 32'h1234_5678 || req0_rdata !== e.data)
                begin errors++; $display("FAIL rm_recover: got %h expected 12345678", req0_rdata); end
        end
    endtask

    task automatic test_clk_div1();
        exp_t e;
        bit got = 0;
        int r1 = -1, r2 = -1;
        logic prev_sck = 1'b0;
        @(posedge clk); #1 b_addr0 = 24'h000200; b_valid0 = 1'b1;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (b_ready0) begin
                got = 1; e.port = 1'b0; e.addr = b_addr0; e.data = exp_word(b_addr0); e.cyc = cyc;
                sb.push_back(e);
            end
        end
        checks++; if (!got) begin errors++; $display("FAIL d1_accept: got no ready expected ready"); end
        @(posedge clk); #1 b_valid0 = 1'b0;
        got = 0;
        for (int n = 0; n < 400 && !got; n++) begin
            @(negedge clk);
            if (b_sck && !prev_sck) begin
                if (r1 < 0) r1 = cyc;
                else if (r2 < 0) r2 = cyc;
            end
            prev_sck = b_sck;
            if (b_rvalid0) got = 1;
        end
        checks++;
        if (!got || sb.size() == 0) begin
            errors++; $display("FAIL d1_rvalid: got timeout expected rvalid");
        end else begin
            e = sb.pop_front();
            checks++; if (cyc - e.cyc != 129) begin errors++; $display("FAIL d1_latency: got %0d expected 129", cyc - e.cyc); end
            checks++; if (r2 - r1 != 2 || r1 - e.cyc != 2) begin errors++; $display("FAIL d1_sck: got period %0d first %0d expected 2 2", r2 - r1, r1 - e.cyc); end
            checks++; if (b_rdata0 !== 32'h1234_5678) begin errors++; $display("FAIL d1_data: got %h expected 12345678", b_rdata0); end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'((i * 37 + 11) & 255);
        mem[256] = 8'h13; mem[257] = 8'h00; mem[258] = 8'h00; mem[259] = 8'h00;
        mem[512] = 8'h78; mem[513] = 8'h56; mem[514] = 8'h34; mem[515] = 8'h12;
        test_reset();
        test_single_read();
        test_endian();
        test_round_robin();
        test_withdraw();
        test_reset_mid();
        test_clk_div1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
